// File: rtl/id_issue_buffer_pkg.sv
// Shared IF/ID definitions: issue width, NOP encoding and the head-window packet.
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 2
`endif

package id_issue_buffer_pkg;

  localparam int unsigned ISSUE_WIDTH = `ISSUE_WIDTH;
  localparam logic [31:0] NOP_INST    = 32'h0000_0013;

  typedef struct packed {
    logic [ISSUE_WIDTH-1:0][31:0] inst;
    logic [ISSUE_WIDTH-1:0][31:0] pc;
    logic [ISSUE_WIDTH-1:0]       valid;
  } IF_ID_PACKET;

endpackage

// File: rtl/issue_count_calc.sv
// Leading-run counter: number of consecutive issuable slots starting at slot 0.
module issue_count_calc #(
  parameter  int unsigned WIDTH = 2,
  localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] valid_i,
  input  logic [WIDTH-1:0] stall_i,
  output logic [CW-1:0]    count_o
);

  logic run;

  always_comb begin
    count_o = '0;
    run     = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      run = run & valid_i[i] & ~stall_i[i];
      if (run) count_o = CW'(i + 1);
    end
  end

endmodule

// File: rtl/id_issue_buffer.sv
// IF/ID issue buffer: circular FIFO between fetch groups and in-order issue.
// Optional ID_ISSUE_BUFFER_STATS_EN adds saturating stall_cycles/full_cycles counters.
module id_issue_buffer
  import id_issue_buffer_pkg::*;
#(
  parameter  int unsigned ISSUE_WIDTH = id_issue_buffer_pkg::ISSUE_WIDTH,
  parameter  int unsigned DEPTH       = 2 * ISSUE_WIDTH,
  localparam int unsigned CNT_W       = $clog2(ISSUE_WIDTH + 1),
  localparam int unsigned OCC_W       = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W       = $clog2(DEPTH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         fetch_valid,
  input  logic [ISSUE_WIDTH-1:0]       fetch_slot_valid,
  input  logic [ISSUE_WIDTH-1:0][31:0] fetch_inst,
  input  logic [ISSUE_WIDTH-1:0][31:0] fetch_pc,
  output logic                         fetch_ready,
  input  logic [ISSUE_WIDTH-1:0]       stall,
  input  logic                         flush,
  output IF_ID_PACKET                  if_id_q,
  output logic [CNT_W-1:0]             issue_count,
  output logic [OCC_W-1:0]             occupancy
`ifdef ID_ISSUE_BUFFER_STATS_EN
  ,
  output logic [31:0]                  stall_cycles,
  output logic [31:0]                  full_cycles
`endif
);

  logic [31:0] inst_q [DEPTH];
  logic [31:0] pc_q   [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic [ISSUE_WIDTH-1:0]            win_valid;
  logic [CNT_W-1:0]                  calc_count, slot_count, pushed;
  logic                              push;
  logic [ISSUE_WIDTH-1:0]            wr_en;
  logic [ISSUE_WIDTH-1:0][PTR_W-1:0] wr_idx;

  assign fetch_ready = (DEPTH - 32'(occ_q)) >= ISSUE_WIDTH;
  assign occupancy   = occ_q;

  always_comb begin
    if_id_q   = '0;
    win_valid = '0;
    for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
      win_valid[i]     = 32'(occ_q) > i;
      if_id_q.valid[i] = win_valid[i];
      if_id_q.inst[i]  = win_valid[i] ? inst_q[head_q + PTR_W'(i)] : NOP_INST;
      if_id_q.pc[i]    = win_valid[i] ? pc_q[head_q + PTR_W'(i)]   : 32'h0;
    end
  end

  issue_count_calc #(.WIDTH(ISSUE_WIDTH)) u_calc (
    .valid_i (win_valid),
    .stall_i (stall),
    .count_o (calc_count)
  );

  assign issue_count = flush ? '0 : calc_count;

  // Valid slots are compacted: each lands at tail plus the count of valid slots below it.
  always_comb begin
    push       = reset & fetch_valid & fetch_ready & ~flush;
    slot_count = '0;
    wr_en      = '0;
    wr_idx     = '0;
    for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
      wr_idx[i] = tail_q + PTR_W'(slot_count);
      wr_en[i]  = push & fetch_slot_valid[i];
      if (fetch_slot_valid[i]) slot_count = slot_count + 1'b1;
    end
    pushed = push ? slot_count : '0;
  end

  always_comb begin
    head_d = head_q + PTR_W'(issue_count);
    tail_d = tail_q + PTR_W'(pushed);
    occ_d  = occ_q + OCC_W'(pushed) - OCC_W'(issue_count);
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
      if (wr_en[i]) begin
        inst_q[wr_idx[i]] <= fetch_inst[i];
        pc_q[wr_idx[i]]   <= fetch_pc[i];
      end
    end
  end

`ifdef ID_ISSUE_BUFFER_STATS_EN
  logic [31:0] stall_cycles_q, full_cycles_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      full_cycles_q  <= '0;
    end else begin
      if (if_id_q.valid[0] && stall[0] && stall_cycles_q != '1)
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if (!fetch_ready && full_cycles_q != '1)
        full_cycles_q <= full_cycles_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign full_cycles  = full_cycles_q;
`endif

endmodule

// File: tb/tb_id_issue_buffer.sv
// Directed bench for id_issue_buffer (ISSUE_WIDTH=2, DEPTH=4) with hand-computed expectations.
module tb_id_issue_buffer;
  import id_issue_buffer_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic [1:0]  fetch_slot_valid;
  logic [1:0][31:0] fetch_inst;
  logic [1:0][31:0] fetch_pc;
  logic        fetch_ready;
  logic [1:0]  stall;
  logic        flush;
  IF_ID_PACKET if_id_q;
  logic [1:0]  issue_count;
  logic [2:0]  occupancy;
`ifdef ID_ISSUE_BUFFER_STATS_EN
  logic [31:0] stall_cycles, full_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  id_issue_buffer #(.ISSUE_WIDTH(2), .DEPTH(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .fetch_valid      (fetch_valid),
    .fetch_slot_valid (fetch_slot_valid),
    .fetch_inst       (fetch_inst),
    .fetch_pc         (fetch_pc),
    .fetch_ready      (fetch_ready),
    .stall            (stall),
    .flush            (flush),
    .if_id_q          (if_id_q),
    .issue_count      (issue_count),
    .occupancy        (occupancy)
`ifdef ID_ISSUE_BUFFER_STATS_EN
    ,
    .stall_cycles     (stall_cycles),
    .full_cycles      (full_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic [1:0] sv, input logic [31:0] i0, input logic [31:0] p0,
                       input logic [31:0] i1, input logic [31:0] p1);
    fetch_valid      = 1'b1;
    fetch_slot_valid = sv;
    fetch_inst[0]    = i0;
    fetch_pc[0]      = p0;
    fetch_inst[1]    = i1;
    fetch_pc[1]      = p1;
  endtask

  task automatic none();
    fetch_valid      = 1'b0;
    fetch_slot_valid = 2'b00;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; stall = 2'b00;
    fetch_valid = 1'b0; fetch_slot_valid = '0; fetch_inst = '0; fetch_pc = '0;
    step();
    reset = 1'b1; #1;
    chk("rst_occ",   64'(occupancy), 0);
    chk("rst_ready", 64'(fetch_ready), 1);
    chk("rst_valid", 64'(if_id_q.valid), 0);
    chk("rst_nop",   64'(if_id_q.inst[0]), 64'(NOP));
    chk("rst_pc",    64'(if_id_q.pc[1]), 0);
    stall = 2'b11; #1;
    chk("empty_issue_stalled", 64'(issue_count), 0);
    stall = 2'b00; #1;
    chk("empty_issue_free", 64'(issue_count), 0);

    // Basic push, load-use stall, then full issue
    offer(2'b11, 32'hA000_0001, 32'h100, 32'hB000_0002, 32'h104);
    stall = 2'b11;
    step();
    none(); stall = 2'b01; #1;
    chk("push_occ",   64'(occupancy), 2);
    chk("push_valid", 64'(if_id_q.valid), 2'b11);
    chk("push_inst0", 64'(if_id_q.inst[0]), 32'hA000_0001);
    chk("push_inst1", 64'(if_id_q.inst[1]), 32'hB000_0002);
    chk("push_pc1",   64'(if_id_q.pc[1]), 32'h104);
    chk("loaduse_issue", 64'(issue_count), 0);
    step();
    stall = 2'b00; #1;
    chk("hold_occ",   64'(occupancy), 2);
    chk("hold_inst0", 64'(if_id_q.inst[0]), 32'hA000_0001);
    chk("full_issue", 64'(issue_count), 2);
    step();
    chk("drain_occ",   64'(occupancy), 0);
    chk("drain_valid", 64'(if_id_q.valid), 0);

    // Partial issue: slot 1 stalled
    offer(2'b11, 32'hA000_0001, 32'h100, 32'hB000_0002, 32'h104);
    stall = 2'b11;
    step();
    none(); stall = 2'b10; #1;
    chk("partial_issue", 64'(issue_count), 1);
    step();
    stall = 2'b11; #1;
    chk("partial_occ",   64'(occupancy), 1);
    chk("partial_inst0", 64'(if_id_q.inst[0]), 32'hB000_0002);
    chk("partial_pc0",   64'(if_id_q.pc[0]), 32'h104);
    chk("partial_valid", 64'(if_id_q.valid), 2'b01);
    stall = 2'b00; #1;
    chk("single_issue", 64'(issue_count), 1);
    step();
    chk("partial_drain", 64'(occupancy), 0);

    // Fill to DEPTH, back-pressure, wrap
    offer(2'b11, 32'hC000_0003, 32'h200, 32'hD000_0004, 32'h204);
    stall = 2'b11;
    step();
    offer(2'b11, 32'hE000_0005, 32'h208, 32'hF000_0006, 32'h20C); #1;
    chk("half_ready", 64'(fetch_ready), 1);
    step();
    offer(2'b11, 32'h6000_0007, 32'h210, 32'h7000_0008, 32'h214); #1;
    chk("fill_occ",   64'(occupancy), 4);
    chk("fill_ready", 64'(fetch_ready), 0);
    step();
    chk("blocked_occ",   64'(occupancy), 4);
    chk("blocked_inst0", 64'(if_id_q.inst[0]), 32'hC000_0003);
    chk("blocked_inst1", 64'(if_id_q.inst[1]), 32'hD000_0004);
    stall = 2'b00; #1;
    chk("fill_issue", 64'(issue_count), 2);
    step();
    chk("after_pop_occ",   64'(occupancy), 2);
    chk("after_pop_inst0", 64'(if_id_q.inst[0]), 32'hE000_0005);
    chk("after_pop_ready", 64'(fetch_ready), 1);
    stall = 2'b11;
    step();
    chk("wrap_fill_occ",   64'(occupancy), 4);
    chk("wrap_fill_inst0", 64'(if_id_q.inst[0]), 32'hE000_0005);
    none(); stall = 2'b00;
    step();
    chk("wrap_occ",   64'(occupancy), 2);
    chk("wrap_inst0", 64'(if_id_q.inst[0]), 32'h6000_0007);
    chk("wrap_inst1", 64'(if_id_q.inst[1]), 32'h7000_0008);
    chk("wrap_pc0",   64'(if_id_q.pc[0]), 32'h210);

    // Simultaneous push and pop
    offer(2'b11, 32'h9000_0009, 32'h300, 32'h9000_000A, 32'h304); #1;
    chk("pushpop_issue", 64'(issue_count), 2);
    chk("pushpop_ready", 64'(fetch_ready), 1);
    step();
    none(); stall = 2'b11; #1;
    chk("pushpop_occ",   64'(occupancy), 2);
    chk("pushpop_inst0", 64'(if_id_q.inst[0]), 32'h9000_0009);
    chk("pushpop_inst1", 64'(if_id_q.inst[1]), 32'h9000_000A);

    // Flush at occupancy 3 with a group on offer
    offer(2'b01, 32'h8000_000B, 32'h308, 32'hDEAD_BEEF, 32'hDEAD);
    step();
    chk("occ3",       64'(occupancy), 3);
    chk("occ3_ready", 64'(fetch_ready), 0);
    flush = 1'b1; stall = 2'b00;
    offer(2'b11, 32'h5000_000C, 32'h400, 32'h5000_000D, 32'h404); #1;
    chk("flush_issue", 64'(issue_count), 0);
    step();
    chk("flush_occ",   64'(occupancy), 0);
    chk("flush_valid", 64'(if_id_q.valid), 0);
    chk("flush_ready", 64'(fetch_ready), 1);
    step();
    flush = 1'b0; none(); #1;
    chk("flush_push_ignored", 64'(occupancy), 0);

    // Only slot 1 valid: compacted to tail
    offer(2'b10, 32'hDEAD_0000, 32'hDEAD, 32'hCC00_00CC, 32'h500);
    stall = 2'b11;
    step();
    none(); #1;
    chk("compact_occ",   64'(occupancy), 1);
    chk("compact_inst0", 64'(if_id_q.inst[0]), 32'hCC00_00CC);
    chk("compact_pc0",   64'(if_id_q.pc[0]), 32'h500);
    chk("compact_valid", 64'(if_id_q.valid), 2'b01);
    chk("compact_nop1",  64'(if_id_q.inst[1]), 64'(NOP));

    // Empty group
    offer(2'b00, 32'h1111_1111, 32'h600, 32'h2222_2222, 32'h604); #1;
    chk("empty_grp_ready", 64'(fetch_ready), 1);
    step();
    none(); #1;
    chk("empty_grp_occ", 64'(occupancy), 1);

    // Reset beats flush/push/pop
    offer(2'b11, 32'hA000_0001, 32'h100, 32'hB000_0002, 32'h104);
    stall = 2'b00; flush = 1'b1; reset = 1'b0;
    step();
    reset = 1'b1; flush = 1'b0; none(); #1;
    chk("midrst_occ",   64'(occupancy), 0);
    chk("midrst_valid", 64'(if_id_q.valid), 0);
    chk("midrst_ready", 64'(fetch_ready), 1);

`ifdef ID_ISSUE_BUFFER_STATS_EN
    chk("stats_rst_stall", 64'(stall_cycles), 0);
    chk("stats_rst_full",  64'(full_cycles), 0);
    offer(2'b11, 32'hA000_0001, 32'h100, 32'hB000_0002, 32'h104);
    stall = 2'b11;
    step();
    none(); stall = 2'b01;
    step();
    step();
    step();
    chk("stats_stall", 64'(stall_cycles), 3);
    chk("stats_full",  64'(full_cycles), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
